// File: rtl/fifo_packetizer.sv
// Pops FIFO words and frames them as AXI4-Stream: one sequence header, then payload.
// Define FIFO_PACKETIZER_STATS_EN to add the frames_sent / stall_cycles counters.
module fifo_packetizer #(
  parameter int DATA_WIDTH    = 64,
  parameter int PAYLOAD_WORDS = 1024,
  parameter int SEQ_WIDTH     = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
`ifdef FIFO_PACKETIZER_STATS_EN
  output logic                  m_axis_tlast,
  output logic [31:0]           frames_sent,
  output logic [31:0]           stall_cycles
`else
  output logic                  m_axis_tlast
`endif
);

  localparam int CW = $clog2(PAYLOAD_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;

  state_t                state;
  logic [SEQ_WIDTH-1:0]  seq;
  logic [CW-1:0]         req_cnt;
  logic [CW-1:0]         out_cnt;
  logic [DATA_WIDTH-1:0] sk0;
  logic [DATA_WIDTH-1:0] sk1;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  pop_out;
  logic [1:0]            occ_after;
  logic [1:0]            pending;

  assign pop_out = (state == PAYLOAD)
                && (occ != 2'd0)
                && m_axis_tready;

  // Occupancy after this cycle's handshake keeps 1 word/cycle sustainable.
  assign occ_after = occ - {1'b0, pop_out};
  assign pending   = occ_after + {1'b0, inflight};

  assign fifo_re = !fifo_empty
                && (state != IDLE)
                && (req_cnt < CW'(PAYLOAD_WORDS))
                && (pending < 2'd2);

  assign m_axis_tvalid = (state == HEADER)
                      || ((state == PAYLOAD) && (occ != 2'd0));

  assign m_axis_tlast = (state == PAYLOAD)
                     && (occ != 2'd0)
                     && (out_cnt == CW'(PAYLOAD_WORDS - 1));

  assign m_axis_tdata = (state == HEADER) ?
                        DATA_WIDTH'(seq) : sk0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      seq      <= '0;
      req_cnt  <= '0;
      out_cnt  <= '0;
      sk0      <= '0;
      sk1      <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_re;
      if (fifo_re) req_cnt <= req_cnt + 1'b1;

      unique case ({inflight, pop_out})
        2'b10: begin
          if (occ == 2'd0) sk0 <= fifo_dout;
          else             sk1 <= fifo_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          sk0 <= sk1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            sk0 <= fifo_dout;
          end else begin
            sk0 <= sk1;
            sk1 <= fifo_dout;
          end
        end
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          if (!fifo_empty) state <= HEADER;
        end
        HEADER: begin
          if (m_axis_tready) state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (pop_out) begin
            if (m_axis_tlast) begin
              seq     <= seq + 1'b1;
              out_cnt <= '0;
              req_cnt <= '0;
              state   <= IDLE;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_PACKETIZER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      frames_sent  <= '0;
      stall_cycles <= '0;
    end else begin
      if (pop_out && m_axis_tlast)
        frames_sent <= frames_sent + 32'd1;
      if ((state == PAYLOAD) && (occ == 2'd0)
          && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_packetizer.sv
// Bench for fifo_packetizer: FIFO model, random tready, stream-order reference model.
// Build with FIFO_PACKETIZER_STATS_EN to also exercise the stats counters.
module tb_fifo_packetizer;

  localparam int DW = 64;
  localparam int PW = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty;
  logic          fifo_re;
  logic [DW-1:0] fifo_dout = '0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
`ifdef FIFO_PACKETIZER_STATS_EN
  logic [31:0]   frames_sent;
  logic [31:0]   stall_cycles;
`endif

  fifo_packetizer #(
    .DATA_WIDTH(DW),
    .PAYLOAD_WORDS(PW),
    .SEQ_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_re(fifo_re),
    .fifo_dout(fifo_dout),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
`ifdef FIFO_PACKETIZER_STATS_EN
    .m_axis_tlast(tlast),
    .frames_sent(frames_sent),
    .stall_cycles(stall_cycles)
`else
    .m_axis_tlast(tlast)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: writer pointer owned by the stimulus, reader by the pop process
  logic [DW-1:0] mem [0:1023];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_re && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  logic [DW-1:0] pq [$];
  logic [DW-1:0] mq [$];
  int            tests = 0;
  int            fails = 0;
  int            pos = 0;
  int            exp_seq = 0;
  int            exp_frames = 0;
  int            cyc = 0;
  int            pops = 0;
  int            h_cyc = 0;
  int            t_cyc = 0;
  bit            hold_v = 0;
  logic [DW-1:0] hold_d;
  logic          hold_l;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(logic [DW-1:0] v);
    pq.push_back(v);
    mq.push_back(v);
  endtask

  task automatic on_hs();
    logic [DW-1:0] d;
    if (pos == 0) begin
      chk("header", tdata, 64'(exp_seq));
      chk("hdr_tlast", {63'd0, tlast}, 64'd0);
      h_cyc = cyc;
      pos = 1;
    end else if (mq.size() == 0) begin
      chk("extra_word", 64'd1, 64'd0);
    end else begin
      d = mq.pop_front();
      chk("payload", tdata, d);
      chk("tlast", {63'd0, tlast}, {63'd0, pos == PW});
      if (pos == PW) begin
        pos = 0;
        exp_seq = (exp_seq + 1) % (1 << SW);
        exp_frames++;
        t_cyc = cyc;
      end else begin
        pos++;
      end
    end
  endtask

  task automatic step(bit rdy);
    @(negedge clk);
    tready = rdy;
    while (pq.size() != 0) begin
      mem[wr_ptr % 1024] = pq.pop_front();
      wr_ptr++;
    end
    #1;
    cyc++;
    if (hold_v) begin
      chk("hold_v", {63'd0, tvalid}, 64'd1);
      chk("hold_d", tdata, hold_d);
      chk("hold_l", {63'd0, tlast}, {63'd0, hold_l});
    end
    if (fifo_re && !fifo_empty) pops++;
    if (tvalid && tready) on_hs();
    hold_v = tvalid && !tready;
    hold_d = tdata;
    hold_l = tlast;
  endtask

  task automatic run_idle(int budget, int pct);
    int n = 0;
    while ((mq.size() != 0 || pos != 0) && n < budget) begin
      step($urandom_range(99) < pct);
      n++;
    end
    if (n >= budget) chk("timeout", 64'd1, 64'd0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_tvalid"}, {63'd0, tvalid}, 64'd0);
    chk({tag, "_tlast"}, {63'd0, tlast}, 64'd0);
    chk({tag, "_tdata"}, tdata, 64'd0);
    chk({tag, "_fifo_re"}, {63'd0, fifo_re}, 64'd0);
`ifdef FIFO_PACKETIZER_STATS_EN
    chk({tag, "_frames"}, {32'd0, frames_sent}, 64'd0);
    chk({tag, "_stalls"}, {32'd0, stall_cycles}, 64'd0);
`endif
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    tready = 1'b0;
    pq.delete();
    mq.delete();
    wr_ptr = rd_ptr;
    @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    pos = 0;
    exp_seq = 0;
    exp_frames = 0;
    hold_v = 0;
  endtask

  initial begin
    repeat (3) step(1'b0);
    reset_dut();

    // Underrun mid-frame
    push(64'd1);
    push(64'd2);
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (i >= 8) chk("gap_tvalid", {63'd0, tvalid}, 64'd0);
    end
    push(64'd3);
    push(64'd4);
    run_idle(200, 100);
    step(1'b1);
`ifdef FIFO_PACKETIZER_STATS_EN
    chk("frames_sent", {32'd0, frames_sent}, 64'(exp_frames));
    chk("stall_cycles", {32'd0, stall_cycles},
        64'(t_cyc - h_cyc - PW));
`endif

    // Basic two frames, next header continues at 1
    pops = 0;
    for (int i = 1; i <= 8; i++) push(64'(i));
    run_idle(200, 100);
    repeat (3) step(1'b1);
    chk("pop_count", 64'(pops), 64'd8);

    // Backpressure with random words
    for (int i = 0; i < 16; i++) push({$urandom, $urandom});
    run_idle(1000, 50);

    // Sequence wrap over 17 frames
    reset_dut();
    for (int f = 0; f < 17; f++) begin
      for (int i = 0; i < PW; i++) push({$urandom, $urandom});
      run_idle(500, 75);
    end
    chk("wrap_seq", 64'(exp_seq), 64'd1);

    // Reset mid-frame after two payload handshakes
    reset_dut();
    for (int i = 0; i < PW; i++) push(64'(100 + i));
    begin
      int n = 0;
      while (pos != 3 && n < 100) begin
        step(1'b1);
        n++;
      end
      if (n >= 100) chk("mid_timeout", 64'd1, 64'd0);
    end
    reset_dut();
    for (int i = 0; i < PW; i++) push(64'(200 + i));
    run_idle(200, 100);
    chk("post_reset_frames", 64'(exp_frames), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
